// File: rtl/mips_inst_profiler_pkg.sv
// Shared definitions for the MIPS-I instruction-stream profiler:
// opcode/funct constants, instruction class and FSM state encodings.
package mips_prof_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SWL    = 6'h2A;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_SWR    = 6'h2E;

  localparam logic [5:0] FN_JR     = 6'h08;

  // jal links into the return-address register
  localparam logic [4:0] REG_RA    = 5'd31;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_J
  } inst_cls_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } prof_state_t;

endpackage

// File: rtl/mips_inst_profiler_if.sv
// Retired-instruction stream from fetch/decode into the profiler.
// Handshake: inst is taken on a rising edge whenever inst_valid is high;
// the stream has no ready/back-pressure, the profiler always accepts.
interface mips_inst_profiler_if;
  logic        inst_valid;
  logic [31:0] inst;

  modport master (output inst_valid, output inst);
  modport slave  (input  inst_valid, input  inst);
endinterface

// File: rtl/mips_inst_profiler_decode.sv
// Combinational MIPS-I decoder: instruction class and destination GPR.
// wr_en is low for instructions that write no GPR and for writes to $0.
module mips_inst_decode
  import mips_prof_pkg::*;
(
  input  logic [31:0] inst,
  output inst_cls_t   cls,
  output logic        wr_en,
  output logic [4:0]  wr_reg
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  // rs and shamt do not affect class or destination
  assign unused_fields = ^{inst[25:21], inst[10:6]};

  // opcode-driven class and destination selection
  always_comb begin
    cls    = CLS_I;
    wr_en  = 1'b0;
    wr_reg = 5'd0;
    case (op)
      OP_RTYPE: begin
        cls    = CLS_R;
        wr_reg = inst[15:11];
        wr_en  = (fn != FN_JR);
      end
      OP_J:   cls = CLS_J;
      OP_JAL: begin
        cls    = CLS_J;
        wr_reg = REG_RA;
        wr_en  = 1'b1;
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: cls = CLS_I;
      default: begin
        wr_reg = inst[20:16];
        wr_en  = 1'b1;
      end
    endcase
    if (wr_reg == 5'd0) wr_en = 1'b0;
  end

endmodule

// File: rtl/mips_inst_profiler.sv
// MIPS-I instruction-stream profiler: counts R/I/J classes, total and
// per-GPR writes for a window of tracked registers, under an
// IDLE/RUN/HOLD control FSM with optional auto-stop after WINDOW.
// Optional feature macro: MIPS_PROF_SAT_EN (saturating counters + ovf).
module mips_inst_profiler
  import mips_prof_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int TRACK_BASE = 3,
  parameter int TRACK_NUM  = 4,
  parameter int SEL_W      = 2,
  parameter int WINDOW     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  mips_inst_profiler_if.slave  stream,
  input  logic [SEL_W-1:0]     reg_sel,
  output logic [CNT_W-1:0]     r_cnt,
  output logic [CNT_W-1:0]     i_cnt,
  output logic [CNT_W-1:0]     j_cnt,
  output logic [CNT_W-1:0]     tot_cnt,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output prof_state_t          fsm_state
);

  localparam bit WIN_EN = (WINDOW != 0);

  prof_state_t          state_q, state_d;
  inst_cls_t            dec_cls;
  logic                 dec_wr_en;
  logic [4:0]           dec_wr_reg;
  logic                 count_en;
  logic                 win_hit;
  logic [CNT_W-1:0]     r_q, i_q, j_q, tot_q, tot_nxt;
  logic [CNT_W-1:0]     wr_q [TRACK_NUM];
  logic [TRACK_NUM-1:0] inc_wr;

  mips_inst_decode u_decode (
    .inst   (stream.inst),
    .cls    (dec_cls),
    .wr_en  (dec_wr_en),
    .wr_reg (dec_wr_reg)
  );

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef MIPS_PROF_SAT_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state: clear beats stop beats start
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!stop && start)     state_d = ST_RUN;
        ST_RUN:  if (stop || win_hit)    state_d = ST_HOLD;
        ST_HOLD: if (!stop && start)     state_d = ST_RUN;
        default:                         state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; the instruction on a stop edge is still counted
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_HOLD);
    count_en  = (state_q == ST_RUN) && stream.inst_valid && !clear;
    fsm_state = state_q;
  end

  // auto-stop compare on the total as it will be stored, plus write decode
  always_comb begin
    tot_nxt = bump(tot_q);
    win_hit = WIN_EN && count_en && (tot_nxt == CNT_W'(WINDOW));
    inc_wr  = '0;
    for (int k = 0; k < TRACK_NUM; k++) begin
      if (count_en && dec_wr_en && (dec_wr_reg == 5'(TRACK_BASE + k)))
        inc_wr[k] = 1'b1;
    end
  end

  // class, total and per-register counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      r_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      tot_q <= '0;
      for (int k = 0; k < TRACK_NUM; k++) wr_q[k] <= '0;
    end else if (count_en) begin
      tot_q <= tot_nxt;
      case (dec_cls)
        CLS_R:   r_q <= bump(r_q);
        CLS_J:   j_q <= bump(j_q);
        default: i_q <= bump(i_q);
      endcase
      for (int k = 0; k < TRACK_NUM; k++) begin
        if (inc_wr[k]) wr_q[k] <= bump(wr_q[k]);
      end
    end
  end

`ifdef MIPS_PROF_SAT_EN
  logic ovf_q;
  logic sat_hit;

  // any counter asked to step past all-ones
  always_comb begin
    sat_hit = 1'b0;
    if (count_en) begin
      if (&tot_q) sat_hit = 1'b1;
      case (dec_cls)
        CLS_R:   if (&r_q) sat_hit = 1'b1;
        CLS_J:   if (&j_q) sat_hit = 1'b1;
        default: if (&i_q) sat_hit = 1'b1;
      endcase
      for (int k = 0; k < TRACK_NUM; k++) begin
        if (inc_wr[k] && (&wr_q[k])) sat_hit = 1'b1;
      end
    end
  end

  // sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear)  ovf_q <= 1'b0;
    else if (sat_hit)  ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // read mux over tracked write counters; out-of-range select reads 0
  always_comb begin
    wr_cnt = '0;
    for (int k = 0; k < TRACK_NUM; k++) begin
      if (reg_sel == SEL_W'(k)) wr_cnt = wr_q[k];
    end
  end

  assign r_cnt   = r_q;
  assign i_cnt   = i_q;
  assign j_cnt   = j_q;
  assign tot_cnt = tot_q;

endmodule

// File: tb/tb_mips_inst_profiler.sv
// Bench for mips_inst_profiler: four instances with different parameters
// share one stimulus stream; each is compared with a reference model that
// applies the profiler rules directly with integer arithmetic.
module tb_mips_inst_profiler;
  import mips_prof_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, stop, clear, inst_valid;
  logic [31:0] inst;
  logic [1:0]  reg_sel;

  int n_tests = 0;
  int n_fail  = 0;

  mips_inst_profiler_if if_a ();
  mips_inst_profiler_if if_b ();
  mips_inst_profiler_if if_c ();
  mips_inst_profiler_if if_d ();
  assign if_a.inst_valid = inst_valid;  assign if_a.inst = inst;
  assign if_b.inst_valid = inst_valid;  assign if_b.inst = inst;
  assign if_c.inst_valid = inst_valid;  assign if_c.inst = inst;
  assign if_d.inst_valid = inst_valid;  assign if_d.inst = inst;

  logic [7:0] r_a, i_a, j_a, t_a, w_a;  logic bz_a, dn_a, ov_a;  prof_state_t s_a;
  logic [7:0] r_b, i_b, j_b, t_b, w_b;  logic bz_b, dn_b, ov_b;  prof_state_t s_b;
  logic [3:0] r_c, i_c, j_c, t_c, w_c;  logic bz_c, dn_c, ov_c;  prof_state_t s_c;
  logic [7:0] r_d, i_d, j_d, t_d, w_d;  logic bz_d, dn_d, ov_d;  prof_state_t s_d;

  // A: defaults
  mips_inst_profiler #(.CNT_W(8), .TRACK_BASE(3), .TRACK_NUM(4), .SEL_W(2), .WINDOW(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .stream(if_a),
    .reg_sel(reg_sel), .r_cnt(r_a), .i_cnt(i_a), .j_cnt(j_a), .tot_cnt(t_a), .wr_cnt(w_a),
    .busy(bz_a), .done(dn_a), .ovf(ov_a), .fsm_state(s_a));
  // B: top four GPRs tracked
  mips_inst_profiler #(.CNT_W(8), .TRACK_BASE(28), .TRACK_NUM(4), .SEL_W(2), .WINDOW(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .stream(if_b),
    .reg_sel(reg_sel), .r_cnt(r_b), .i_cnt(i_b), .j_cnt(j_b), .tot_cnt(t_b), .wr_cnt(w_b),
    .busy(bz_b), .done(dn_b), .ovf(ov_b), .fsm_state(s_b));
  // C: narrow counters
  mips_inst_profiler #(.CNT_W(4), .TRACK_BASE(3), .TRACK_NUM(4), .SEL_W(2), .WINDOW(0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .stream(if_c),
    .reg_sel(reg_sel), .r_cnt(r_c), .i_cnt(i_c), .j_cnt(j_c), .tot_cnt(t_c), .wr_cnt(w_c),
    .busy(bz_c), .done(dn_c), .ovf(ov_c), .fsm_state(s_c));
  // D: auto-stop after 5
  mips_inst_profiler #(.CNT_W(8), .TRACK_BASE(3), .TRACK_NUM(4), .SEL_W(2), .WINDOW(5)) dut_d (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .stream(if_d),
    .reg_sel(reg_sel), .r_cnt(r_d), .i_cnt(i_d), .j_cnt(j_d), .tot_cnt(t_d), .wr_cnt(w_d),
    .busy(bz_d), .done(dn_d), .ovf(ov_d), .fsm_state(s_d));

  // ---------------- reference model ----------------
  int m_cw  [4] = '{8, 8, 4, 8};
  int m_base[4] = '{3, 28, 3, 3};
  int m_win [4] = '{0, 0, 0, 5};
  int m_st[4];  // 0 idle, 1 run, 2 hold
  int m_r[4], m_i[4], m_j[4], m_t[4], m_ovf[4];
  int m_w[4][4];
`ifdef MIPS_PROF_SAT_EN
  bit sat_mode = 1'b1;
`else
  bit sat_mode = 1'b0;
`endif

  function automatic int bumpm(int k, int v);
    int lim = (1 << m_cw[k]) - 1;
    if (v == lim) begin
      if (sat_mode) begin
        m_ovf[k] = 1;
        return v;
      end
      return 0;
    end
    return v + 1;
  endfunction

  // class: 0=R 1=I 2=J; dest -1 means no GPR write
  function automatic void classify(input logic [31:0] w, output int cls, output int dest);
    int op = int'(w[31:26]);
    if (op == 0) begin
      cls  = 0;
      dest = (w[5:0] == 6'h08) ? -1 : int'(w[15:11]);
    end else if (op == 2) begin
      cls = 2; dest = -1;
    end else if (op == 3) begin
      cls = 2; dest = 31;
    end else begin
      cls  = 1;
      dest = (op inside {1, 4, 5, 6, 7, 'h28, 'h29, 'h2A, 'h2B, 'h2E}) ? -1 : int'(w[20:16]);
    end
    if (dest == 0) dest = -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_st[k] = 0; m_r[k] = 0; m_i[k] = 0; m_j[k] = 0; m_t[k] = 0; m_ovf[k] = 0;
      for (int s = 0; s < 4; s++) m_w[k][s] = 0;
    end
  endtask

  // advance the model by one rising edge using the current inputs
  task automatic model_step();
    int cls, dest;
    bit counted;
    classify(inst, cls, dest);
    for (int k = 0; k < 4; k++) begin
      if (clear) begin
        m_st[k] = 0; m_r[k] = 0; m_i[k] = 0; m_j[k] = 0; m_t[k] = 0; m_ovf[k] = 0;
        for (int s = 0; s < 4; s++) m_w[k][s] = 0;
      end else begin
        counted = (m_st[k] == 1) && inst_valid;
        if (counted) begin
          m_t[k] = bumpm(k, m_t[k]);
          if (cls == 0)      m_r[k] = bumpm(k, m_r[k]);
          else if (cls == 1) m_i[k] = bumpm(k, m_i[k]);
          else               m_j[k] = bumpm(k, m_j[k]);
          if (dest >= m_base[k] && dest < m_base[k] + 4)
            m_w[k][dest - m_base[k]] = bumpm(k, m_w[k][dest - m_base[k]]);
        end
        if (m_st[k] == 1) begin
          if (stop || (m_win[k] != 0 && counted && m_t[k] == m_win[k])) m_st[k] = 2;
        end else if (start && !stop) begin
          m_st[k] = 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int k, output logic [31:0] r, output logic [31:0] i,
                         output logic [31:0] j, output logic [31:0] t, output logic [31:0] w,
                         output logic [31:0] bz, output logic [31:0] dn, output logic [31:0] ov);
    case (k)
      0: begin r = 32'(r_a); i = 32'(i_a); j = 32'(j_a); t = 32'(t_a); w = 32'(w_a);
               bz = 32'(bz_a); dn = 32'(dn_a); ov = 32'(ov_a); end
      1: begin r = 32'(r_b); i = 32'(i_b); j = 32'(j_b); t = 32'(t_b); w = 32'(w_b);
               bz = 32'(bz_b); dn = 32'(dn_b); ov = 32'(ov_b); end
      2: begin r = 32'(r_c); i = 32'(i_c); j = 32'(j_c); t = 32'(t_c); w = 32'(w_c);
               bz = 32'(bz_c); dn = 32'(dn_c); ov = 32'(ov_c); end
      default: begin r = 32'(r_d); i = 32'(i_d); j = 32'(j_d); t = 32'(t_d); w = 32'(w_d);
               bz = 32'(bz_d); dn = 32'(dn_d); ov = 32'(ov_d); end
    endcase
  endtask

  // compares every output of every instance; consumes 4 time units
  task automatic check_all(input string tag);
    logic [31:0] r, i, j, t, w, bz, dn, ov;
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s);
      #1;
      for (int k = 0; k < 4; k++) begin
        get_obs(k, r, i, j, t, w, bz, dn, ov);
        chk($sformatf("%s.%0d.wr%0d", tag, k, s), w, 32'(m_w[k][s]));
        if (s == 0) begin
          chk($sformatf("%s.%0d.r", tag, k), r, 32'(m_r[k]));
          chk($sformatf("%s.%0d.i", tag, k), i, 32'(m_i[k]));
          chk($sformatf("%s.%0d.j", tag, k), j, 32'(m_j[k]));
          chk($sformatf("%s.%0d.tot", tag, k), t, 32'(m_t[k]));
          chk($sformatf("%s.%0d.busy", tag, k), bz, 32'(m_st[k] == 1));
          chk($sformatf("%s.%0d.done", tag, k), dn, 32'(m_st[k] == 2));
          chk($sformatf("%s.%0d.ovf", tag, k), ov, 32'(m_ovf[k]));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();  start = 1'b1; cycle(); start = 1'b0;  endtask
  task automatic do_stop();   stop  = 1'b1; cycle(); stop  = 1'b0;  endtask
  task automatic do_clear();  clear = 1'b1; cycle(); clear = 1'b0;  endtask

  task automatic feed(input logic [31:0] w);
    inst_valid = 1'b1; inst = w; cycle(); inst_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    int ops[13] = '{0, 0, 0, 1, 2, 3, 4, 7, 8, 'h0D, 'h23, 'h2B, 'h2E};
    logic [31:0] raw = $urandom();
    logic [5:0]  op  = 6'(ops[$urandom_range(0, 12)]);
    logic [31:0] w   = {op, raw[25:0]};
    if (op == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = 6'h08;
    return w;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    inst_valid = 1'b0; inst = 32'h0; reg_sel = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset");

    // basic class and write counting
    do_start();
    feed(32'h20043456);  // addi $4
    feed(32'h00A43020);  // add $6
    feed(32'h08123456);  // j
    check_all("basic");

    // jal writes $31, jr writes nothing
    do_clear(); do_start();
    feed(32'h0C000010);
    feed(32'h03E00008);
    check_all("jal_jr");

    // no-write I-types
    do_clear(); do_start();
    feed(32'hAC850004);  // sw
    feed(32'h10850003);  // beq
    feed(32'h20000005);  // addi $0
    check_all("nowrite");

    // auto-stop window with back-to-back add $3
    do_clear(); do_start();
    for (int n = 0; n < 8; n++) feed(32'h00001820);
    check_all("window");

    // valid while HOLD, then resume; stop edge instruction is counted
    feed(32'h00001820);
    check_all("hold_valid");
    do_start();
    feed(32'h20030001);
    inst_valid = 1'b1; inst = 32'h20030001; stop = 1'b1; cycle();
    stop = 1'b0; inst_valid = 1'b0;
    check_all("stop_edge");
    do_start();
    feed(32'h0C000000);
    check_all("resume");

    // clear with start beats start; valid while IDLE not counted
    clear = 1'b1; start = 1'b1; cycle(); clear = 1'b0; start = 1'b0;
    feed(32'h00001820);
    check_all("clear_start");

    // stop together with start in IDLE keeps IDLE
    stop = 1'b1; start = 1'b1; cycle(); stop = 1'b0; start = 1'b0;
    check_all("stop_start_idle");

    // 17 R-types: narrow instance wraps or saturates
    do_clear(); do_start();
    for (int n = 0; n < 17; n++) feed(32'h00A41820);
    check_all("overflow");

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("post_rst");

    // randomized control and instruction stream
    for (int n = 0; n < 400; n++) begin
      start      = ($urandom_range(0, 5) == 0);
      stop       = ($urandom_range(0, 14) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      inst_valid = ($urandom_range(0, 9) < 7);
      inst       = rand_inst();
      cycle();
      if (n % 4 == 3) check_all($sformatf("rand%0d", n));
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; inst_valid = 1'b0;
    cycle();
    check_all("rand_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
